move_digit_ctrl: RTL and testbench

MOVE_DIGIT_CTRL -- requirements
Module: move_digit_ctrl

---
 rtl/move_digit_ctrl.sv | 116 +++++++++++
 tb/tb_move_digit_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/move_digit_ctrl.sv
// Bouncing-digit motion controller: slides a digit between the display walls,
// pausing at each wall and advancing the shown BCD value on every arrival.
module move_digit_ctrl #(
    parameter int unsigned OLED_WIDTH  = 96,
    parameter int unsigned DIGIT_WIDTH = 16,
    parameter int unsigned TICK_DIV    = 1800000,
    parameter int unsigned PAUSE_TICKS = 8,
    parameter int unsigned BASE_Y      = 20,
    parameter int unsigned START_VALUE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       restart,
    output logic [6:0] base_x,
    output logic [6:0] base_y,
    output logic [3:0] value,
    output logic       moving,
    output logic       bounce
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PW = $clog2(PAUSE_TICKS + 1);
    localparam logic [6:0]    MAX_X      = 7'(OLED_WIDTH - DIGIT_WIDTH);
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
    localparam logic [3:0]    START_BCD  = 4'(START_VALUE);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_R,
        PAUSE_R,
        MOVE_L,
        PAUSE_L
    } state_t;

    state_t        state;
    logic [CW-1:0] prescale;
    logic [PW-1:0] pause_cnt;
    logic          tick;
    logic [3:0]    next_value;

    assign base_y = 7'(BASE_Y);

    always_comb begin
        tick       = en && (state != IDLE) && (prescale == TICK_LAST);
        next_value = (value == 4'd9) ? 4'd0 : value + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            state     <= IDLE;
            base_x    <= '0;
            value     <= START_BCD;
            moving    <= 1'b0;
            bounce    <= 1'b0;
            prescale  <= '0;
            pause_cnt <= '0;
        end else begin
            bounce <= 1'b0;
            if (en) begin
                // Prescaler is parked at 0 while idle so the first step is a full period away.
                if (state != IDLE)
                    prescale <= tick ? '0 : prescale + CW'(1);

                case (state)
                    IDLE: begin
                        state  <= MOVE_R;
                        moving <= 1'b1;
                    end
                    MOVE_R: if (tick) begin
                        base_x <= base_x + 7'd1;
                        if (base_x == MAX_X - 7'd1) begin
                            state     <= PAUSE_R;
                            moving    <= 1'b0;
                            bounce    <= 1'b1;
                            value     <= next_value;
                            pause_cnt <= '0;
                        end
                    end
                    PAUSE_R: if (tick) begin
                        if (pause_cnt == PAUSE_LAST) begin
                            state  <= MOVE_L;
                            moving <= 1'b1;
                        end else begin
                            pause_cnt <= pause_cnt + PW'(1);
                        end
                    end
                    MOVE_L: if (tick) begin
                        base_x <= base_x - 7'd1;
                        if (base_x == 7'd1) begin
                            state     <= PAUSE_L;
                            moving    <= 1'b0;
                            bounce    <= 1'b1;
                            value     <= next_value;
                            pause_cnt <= '0;
                        end
                    end
                    PAUSE_L: if (tick) begin
                        if (pause_cnt == PAUSE_LAST) begin
                            state  <= MOVE_R;
                            moving <= 1'b1;
                        end else begin
                            pause_cnt <= pause_cnt + PW'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_digit_ctrl.sv
// Checks move_digit_ctrl against a closed-form trajectory model driven by the
// count of motion ticks since leaving IDLE.
module tb_move_digit_ctrl;

    localparam int MX = 8;
    localparam int TD = 4;
    localparam int PT = 2;
    localparam int SV = 7;
    localparam int BY = 20;
    localparam int P  = 2 * MX + 2 * PT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic [6:0] base_x;
    logic [6:0] base_y;
    logic [3:0] value;
    logic       moving;
    logic       bounce;

    int vectors = 0;
    int miscompares = 0;

    // Model: started flag, prescaler phase, ticks elapsed, bounce pulse.
    bit m_started = 0;
    int m_cyc = 0;
    int m_n = 0;
    bit m_bounce = 0;

    move_digit_ctrl #(
        .OLED_WIDTH (24),
        .DIGIT_WIDTH(16),
        .TICK_DIV   (TD),
        .PAUSE_TICKS(PT),
        .BASE_Y     (BY),
        .START_VALUE(SV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(restart),
        .base_x (base_x),
        .base_y (base_y),
        .value  (value),
        .moving (moving),
        .bounce (bounce)
    );

    always #5 clk = ~clk;

    function automatic int pos(int n);
        int r = n % P;
        if (r < MX) return r;
        if (r < MX + PT) return MX;
        if (r < 2 * MX + PT) return MX - (r - MX - PT);
        return 0;
    endfunction

    function automatic bit paused(int n);
        int r = n % P;
        return (r >= MX && r < MX + PT) || (r >= 2 * MX + PT);
    endfunction

    function automatic bit wall(int n);
        int r = n % P;
        return (n > 0) && (r == MX || r == 2 * MX + PT);
    endfunction

    function automatic int val(int n);
        int r = n % P;
        return (SV + 2 * (n / P) + int'(r >= MX) + int'(r >= 2 * MX + PT)) % 10;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst_i, input bit en_i, input bit rs_i);
        reset   = rst_i;
        en      = en_i;
        restart = rs_i;
        @(posedge clk);
        if (!rst_i || rs_i) begin
            m_started = 0; m_cyc = 0; m_n = 0; m_bounce = 0;
        end else if (!en_i) begin
            m_bounce = 0;
        end else if (!m_started) begin
            m_started = 1; m_bounce = 0;
        end else if (m_cyc == TD - 1) begin
            m_cyc = 0; m_n++; m_bounce = wall(m_n);
        end else begin
            m_cyc++; m_bounce = 0;
        end
        #1;
        check("base_x", int'(base_x), pos(m_n));
        check("base_y", int'(base_y), BY);
        check("value", int'(value), val(m_n));
        check("moving", int'(moving), int'(m_started && !paused(m_n)));
        check("bounce", int'(bounce), int'(m_bounce));
        check("x_range", int'(base_x <= 7'(MX)), 1);
    endtask

    initial begin
        int guard;

        step(0, 0, 0);
        step(0, 1, 1);
        step(1, 0, 0);
        step(1, 0, 0);

        // Three round trips uninterrupted.
        for (int i = 0; i < 3 * P * TD + 4; i++) step(1, 1, 0);

        // Freeze mid-MOVE_L at x=5 for 10 cycles.
        guard = 0;
        while (!(m_started && !paused(m_n) && (m_n % P) > MX && pos(m_n) == 5 && m_cyc == 1)
               && guard < 200) begin
            step(1, 1, 0); guard++;
        end
        check("wait_movel5", int'(guard < 200), 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0);

        // Restart coincident with a wall-arrival tick.
        guard = 0;
        while (!(m_started && m_cyc == TD - 1 && wall(m_n + 1)) && guard < 200) begin
            step(1, 1, 0); guard++;
        end
        check("wait_wall", int'(guard < 200), 1);
        step(1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0);

        // Reset during PAUSE_L, alone and together with restart.
        for (int k = 0; k < 2; k++) begin
            guard = 0;
            while (!(m_started && (m_n % P) >= 2 * MX + PT) && guard < 300) begin
                step(1, 1, 0); guard++;
            end
            check("wait_pausel", int'(guard < 300), 1);
            step(0, 1, k[0]);
            step(1, 1, 0);
        end

        // Randomized enable, restart and reset activity.
        for (int i = 0; i < 3000; i++) begin
            bit e, rs, rst;
            e   = ($urandom_range(0, 9) != 0);
            rs  = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 499) != 0);
            if (m_started && m_cyc == TD - 1 && wall(m_n + 1) && $urandom_range(0, 7) == 0)
                rs = 1;
            step(rst, e, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
